// File: rtl/cv32e40p_rf_wb_arbiter.sv
// Writeback arbiter for the two register-file write ports (W1/W2).
// Priority: starved requesters, then EX (index 0), then round-robin over the rest. Outputs are registered.
module cv32e40p_rf_wb_arbiter #(
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REQ      = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  output logic [ADDR_WIDTH-1:0]           waddr_a_o,
  output logic [DATA_WIDTH-1:0]           wdata_a_o,
  output logic                            we_a_o,
  output logic [ADDR_WIDTH-1:0]           waddr_b_o,
  output logic [DATA_WIDTH-1:0]           wdata_b_o,
  output logic                            we_b_o,
  output logic [2**ADDR_WIDTH-1:0]        pending_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [ADDR_WIDTH-1:0] addr [NUM_REQ];
  logic [DATA_WIDTH-1:0] data [NUM_REQ];
  logic [CNT_W-1:0]      wait_cnt [NUM_REQ];
  logic [NUM_REQ-1:0]    starved, eligible, x0_req, grant;
  logic [IDX_W-1:0]      rr_ptr, rr_ptr_next;
  logic [IDX_W-1:0]      sel_a, sel_b;
  logic                  have_a, have_b;
  logic [2**ADDR_WIDTH-1:0] pending_next;
  int                    rank [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr[g]     = req_addr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign data[g]     = req_wdata_i[g*DATA_WIDTH +: DATA_WIDTH];
    assign x0_req[g]   = req_valid_i[g] && (addr[g] == '0);
    assign eligible[g] = req_valid_i[g] && (addr[g] != '0);
    assign starved[g]  = (wait_cnt[g] == CNT_W'(STARVE_LIMIT));
  end

  // Candidate position: starved by index, then EX, then round-robin distance from rr_ptr.
  always_comb begin
    int off;
    for (int i = 0; i < NUM_REQ; i++) begin
      off = int'(i) - int'(rr_ptr);
      if (off < 0) off = off + (NUM_REQ - 1);
      if (starved[i])  rank[i] = i;
      else if (i == 0) rank[i] = NUM_REQ;
      else             rank[i] = NUM_REQ + 1 + off;
    end
  end

  always_comb begin
    have_a      = 1'b0;
    have_b      = 1'b0;
    sel_a       = '0;
    sel_b       = '0;
    grant       = '0;
    rr_ptr_next = rr_ptr;
    // NOTE: blocking assignments are required here: later loop iterations must see have_a/sel_a set by earlier ones.
    for (int r = 0; r < 2*NUM_REQ; r++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (eligible[i] && rank[i] == r) begin
          if (!have_a) begin
            have_a   = 1'b1;
            sel_a    = IDX_W'(i);
            grant[i] = 1'b1;
          end else if (!have_b && addr[i] != addr[sel_a]) begin
            have_b   = 1'b1;
            sel_b    = IDX_W'(i);
            grant[i] = 1'b1;
          end
        end
      end
    end
    // Ascending scan leaves the pointer just past the highest granted round-robin requester.
    for (int i = 1; i < NUM_REQ; i++) begin
      if (grant[i]) rr_ptr_next = (i == NUM_REQ - 1) ? IDX_W'(1) : IDX_W'(i + 1);
    end
    pending_next = '0;
    if (have_a) pending_next[addr[sel_a]] = 1'b1;
    if (have_b) pending_next[addr[sel_b]] = 1'b1;
  end

  assign req_ready_o = rst ? '0 : (grant | x0_req);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= IDX_W'(1);
      we_a_o    <= 1'b0;
      we_b_o    <= 1'b0;
      waddr_a_o <= '0;
      wdata_a_o <= '0;
      waddr_b_o <= '0;
      wdata_b_o <= '0;
      pending_o <= '0;
      for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] <= '0;
    end else begin
      rr_ptr    <= rr_ptr_next;
      we_a_o    <= have_a;
      we_b_o    <= have_b;
      pending_o <= pending_next;
      if (have_a) begin
        waddr_a_o <= addr[sel_a];
        wdata_a_o <= data[sel_a];
      end
      if (have_b) begin
        waddr_b_o <= addr[sel_b];
        wdata_b_o <= data[sel_b];
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid_i[i] && !req_ready_o[i]) begin
          if (!starved[i]) wait_cnt[i] <= wait_cnt[i] + 1'b1;
        end else begin
          wait_cnt[i] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cv32e40p_rf_wb_arbiter.sv
// Self-checking bench for cv32e40p_rf_wb_arbiter: directed table, hand sequences, and random traffic vs a queue-based model.
module tb_cv32e40p_rf_wb_arbiter;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int N  = 3;
  localparam int SL = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready;
  logic [AW-1:0]   waddr_a, waddr_b;
  logic [DW-1:0]   wdata_a, wdata_b;
  logic            we_a, we_b;
  logic [63:0]     pending;

  cv32e40p_rf_wb_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(N), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_ready_o(req_ready),
    .waddr_a_o(waddr_a), .wdata_a_o(wdata_a), .we_a_o(we_a),
    .waddr_b_o(waddr_b), .wdata_b_o(wdata_b), .we_b_o(we_b),
    .pending_o(pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model state
  int            wcnt [N];
  int            rr;
  logic [N-1:0]  m_ready;
  logic          m_we_a, m_we_b;
  logic [AW-1:0] m_wa, m_wb;
  logic [DW-1:0] m_da, m_db;
  logic [63:0]   m_pend;
  logic [N-1:0]  got_ready;

  task automatic model_eval(input logic [N-1:0] v, input logic [N*AW-1:0] a,
                            input logic [N*DW-1:0] d, input logic r);
    int cand[$];
    int ga, gb, hi, idx;
    logic [AW-1:0] ad [N];
    for (int i = 0; i < N; i++) ad[i] = a[i*AW +: AW];
    if (r) begin
      m_ready = '0;
      for (int i = 0; i < N; i++) wcnt[i] = 0;
      rr = 1;
      m_we_a = 0; m_we_b = 0; m_wa = '0; m_wb = '0; m_da = '0; m_db = '0; m_pend = '0;
      return;
    end
    for (int i = 0; i < N; i++)
      if (v[i] && ad[i] != 0 && wcnt[i] == SL) cand.push_back(i);
    if (v[0] && ad[0] != 0 && wcnt[0] != SL) cand.push_back(0);
    for (int k = 0; k < N-1; k++) begin
      idx = 1 + ((rr - 1 + k) % (N - 1));
      if (v[idx] && ad[idx] != 0 && wcnt[idx] != SL) cand.push_back(idx);
    end
    ga = -1; gb = -1;
    foreach (cand[k]) begin
      if (ga < 0) ga = cand[k];
      else if (gb < 0 && ad[cand[k]] != ad[ga]) gb = cand[k];
    end
    for (int i = 0; i < N; i++)
      m_ready[i] = (v[i] && ad[i] == 0) || i == ga || i == gb;
    hi = -1;
    if (ga >= 1) hi = ga;
    if (gb >= 1 && gb > hi) hi = gb;
    if (hi >= 1) rr = (hi + 1 > N - 1) ? 1 : hi + 1;
    for (int i = 0; i < N; i++)
      wcnt[i] = (v[i] && !m_ready[i]) ? ((wcnt[i] + 1 > SL) ? SL : wcnt[i] + 1) : 0;
    m_we_a = (ga >= 0);
    m_we_b = (gb >= 0);
    m_pend = '0;
    if (ga >= 0) begin m_wa = ad[ga]; m_da = d[ga*DW +: DW]; m_pend[ad[ga]] = 1'b1; end
    if (gb >= 0) begin m_wb = ad[gb]; m_db = d[gb*DW +: DW]; m_pend[ad[gb]] = 1'b1; end
  endtask

  // One clock cycle: drive, check ready vs model, clock, check registered outputs vs model.
  task automatic cycle(input logic [N-1:0] v, input logic [N*AW-1:0] a,
                       input logic [N*DW-1:0] d, input logic r);
    req_valid = v; req_addr = a; req_wdata = d; rst = r;
    #1;
    model_eval(v, a, d, r);
    got_ready = req_ready;
    check("model ready", req_ready, m_ready);
    @(posedge clk);
    #1;
    check("model we_a", we_a, m_we_a);
    check("model we_b", we_b, m_we_b);
    check("model waddr_a", waddr_a, m_wa);
    check("model waddr_b", waddr_b, m_wb);
    check("model wdata_a", wdata_a, m_da);
    check("model wdata_b", wdata_b, m_db);
    check("model pending", pending, m_pend);
  endtask

  function automatic logic [N*AW-1:0] pa(input int a0, input int a1, input int a2);
    return {AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  function automatic logic [N*DW-1:0] pd(input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    return {d2, d1, d0};
  endfunction

  typedef struct {
    logic [N-1:0]  v;
    int            a0, a1, a2;
    logic [DW-1:0] d0, d1, d2;
    logic [N-1:0]  ready;
    logic          we_a;
    logic [AW-1:0] waddr_a;
    logic [DW-1:0] wdata_a;
    logic          we_b;
    logic [AW-1:0] waddr_b;
    logic [63:0]   pend;
  } vec_t;

  vec_t tv [5];

  initial begin
    logic [N-1:0]  cv;
    logic [AW-1:0] ca [N];
    logic [DW-1:0] cd [N];
    logic [DW-1:0] ex_d;
    logic          lsu_v;
    logic [N-1:0]  exp_r;

    tv[0] = '{v:3'b001, a0:5, a1:0, a2:0, d0:32'hDEADBEEF, d1:0, d2:0,
              ready:3'b001, we_a:1, waddr_a:5, wdata_a:32'hDEADBEEF, we_b:0, waddr_b:0, pend:64'h20};
    tv[1] = '{v:3'b111, a0:3, a1:7, a2:9, d0:32'h11, d1:32'h22, d2:32'h33,
              ready:3'b011, we_a:1, waddr_a:3, wdata_a:32'h11, we_b:1, waddr_b:7, pend:64'h88};
    tv[2] = '{v:3'b100, a0:0, a1:0, a2:9, d0:0, d1:0, d2:32'h33,
              ready:3'b100, we_a:1, waddr_a:9, wdata_a:32'h33, we_b:0, waddr_b:7, pend:64'h200};
    tv[3] = '{v:3'b111, a0:2, a1:0, a2:33, d0:32'h44, d1:32'h66, d2:32'h55,
              ready:3'b111, we_a:1, waddr_a:2, wdata_a:32'h44, we_b:1, waddr_b:33, pend:(64'h4 | (64'h1 << 33))};
    tv[4] = '{v:3'b000, a0:0, a1:0, a2:0, d0:0, d1:0, d2:0,
              ready:3'b000, we_a:0, waddr_a:2, wdata_a:32'h44, we_b:0, waddr_b:33, pend:64'h0};

    cycle('0, '0, '0, 1'b1);
    cycle('0, '0, '0, 1'b1);
    check("reset we_a", we_a, 0);
    check("reset pending", pending, 0);

    for (int k = 0; k < 5; k++) begin
      cycle(tv[k].v, pa(tv[k].a0, tv[k].a1, tv[k].a2), pd(tv[k].d0, tv[k].d1, tv[k].d2), 1'b0);
      check($sformatf("tbl%0d ready", k), got_ready, tv[k].ready);
      check($sformatf("tbl%0d we_a", k), we_a, tv[k].we_a);
      check($sformatf("tbl%0d waddr_a", k), waddr_a, tv[k].waddr_a);
      check($sformatf("tbl%0d wdata_a", k), wdata_a, tv[k].wdata_a);
      check($sformatf("tbl%0d we_b", k), we_b, tv[k].we_b);
      check($sformatf("tbl%0d waddr_b", k), waddr_b, tv[k].waddr_b);
      check($sformatf("tbl%0d pending", k), pending, tv[k].pend);
    end

    // Same-address collision: EX wins, LSU follows next cycle on W1.
    cycle(3'b011, pa(4, 4, 0), pd(32'hA0, 32'hA1, 0), 1'b0);
    check("t3 c0 ready", got_ready, 3'b001);
    check("t3 c0 wdata_a", wdata_a, 32'hA0);
    check("t3 c0 we_b", we_b, 0);
    cycle(3'b010, pa(4, 4, 0), pd(0, 32'hA1, 0), 1'b0);
    check("t3 c1 ready", got_ready, 3'b010);
    check("t3 c1 waddr_a", waddr_a, 4);
    check("t3 c1 wdata_a", wdata_a, 32'hA1);
    cycle('0, '0, '0, 1'b0);

    // Starvation: LSU stalled SL cycles behind EX on the same address, then overtakes it.
    ex_d = 32'h100;
    lsu_v = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cycle({1'b0, lsu_v, 1'b1}, pa(6, 6, 0), pd(ex_d, 32'hBBBB, 0), 1'b0);
      exp_r = (c < SL) ? 3'b001 : (c == SL) ? 3'b010 : 3'b001;
      check($sformatf("t4 c%0d ready", c), got_ready, exp_r);
      if (c == SL) check("t4 starved data", wdata_a, 32'hBBBB);
      if (got_ready[0]) ex_d = ex_d + 1;
      if (got_ready[1]) lsu_v = 1'b0;
    end
    cycle('0, '0, '0, 1'b0);

    // Reset mid-operation; a request offered during reset is not accepted.
    cycle(3'b001, pa(8, 0, 0), pd(32'h8, 0, 0), 1'b0);
    check("t6 c0 waddr_a", waddr_a, 8);
    cycle(3'b001, pa(9, 0, 0), pd(32'h9, 0, 0), 1'b1);
    check("t6 rst ready", got_ready, 3'b000);
    check("t6 rst we_a", we_a, 0);
    check("t6 rst waddr_a", waddr_a, 0);
    check("t6 rst pending", pending, 0);
    cycle(3'b001, pa(9, 0, 0), pd(32'h9, 0, 0), 1'b0);
    check("t6 after ready", got_ready, 3'b001);
    check("t6 after waddr_a", waddr_a, 9);

    // Random traffic against the model with handshake-stable requests.
    cv = '0;
    for (int i = 0; i < N; i++) begin ca[i] = '0; cd[i] = '0; end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      logic [N*AW-1:0] ap;
      logic [N*DW-1:0] dp;
      for (int i = 0; i < N; i++) begin
        if (!cv[i]) begin
          cv[i] = ($urandom_range(0, 99) < 60);
          case ($urandom_range(0, 5))
            0: ca[i] = 6'd0;
            1: ca[i] = 6'd1;
            2: ca[i] = 6'd2;
            3: ca[i] = 6'd3;
            4: ca[i] = 6'd33;
            default: ca[i] = 6'd63;
          endcase
          cd[i] = $urandom;
        end
        ap[i*AW +: AW] = ca[i];
        dp[i*DW +: DW] = cd[i];
      end
      cycle(cv, ap, dp, ($urandom_range(0, 49) == 0));
      for (int i = 0; i < N; i++) if (cv[i] && got_ready[i]) cv[i] = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
